// File: rtl/pipeline_hazard_ctrl_pkg.sv
// pipeline_ctrl_pkg: state encoding and cycle-count helpers shared by the hazard controller
package pipeline_ctrl_pkg;
   typedef enum logic [1:0] {RUN = 2'd0, LSTALL = 2'd1, FLUSH = 2'd2, XSTALL = 2'd3} ctrl_state_e;
   localparam int CYC_W = 3;
   localparam int CNT_W_DEF = 16;
   function automatic logic [CYC_W-1:0] cyc_load(input int cyc);
      return (cyc > 1) ? CYC_W'(cyc - 1) : '0;
   endfunction
endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if: ID-stage hazard inputs and pipeline register control outputs
interface pipeline_hazard_ctrl_if;
   logic [4:0] if_id_rs1;
   logic [4:0] if_id_rs2;
   logic [4:0] id_ex_rd;
   logic       id_ex_mem_read;
   logic       branch_taken;
   logic       ext_stall_req;
   logic       pc_write;
   logic       if_id_write;
   logic       if_id_flush;
   logic       id_ex_bubble;
   logic       id_ex_write;
   modport master (
      output if_id_rs1, if_id_rs2, id_ex_rd, id_ex_mem_read, branch_taken, ext_stall_req,
      input  pc_write, if_id_write, if_id_flush, id_ex_bubble, id_ex_write
   );
   modport slave (
      input  if_id_rs1, if_id_rs2, id_ex_rd, id_ex_mem_read, branch_taken, ext_stall_req,
      output pc_write, if_id_write, if_id_flush, id_ex_bubble, id_ex_write
   );
endinterface

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// load_use_detect: combinational load-use comparator, x0 never creates a dependency
module load_use_detect (
   input  logic       id_ex_mem_read_i,
   input  logic [4:0] id_ex_rd_i,
   input  logic [4:0] if_id_rs1_i,
   input  logic [4:0] if_id_rs2_i,
   output logic       hazard_o
);
   assign hazard_o = id_ex_mem_read_i && (id_ex_rd_i != 5'd0) &&
                     ((id_ex_rd_i == if_id_rs1_i) || (id_ex_rd_i == if_id_rs2_i));
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stretches load-use, branch and memory-stall events into PC/IF_ID/ID_EX controls
module pipeline_hazard_ctrl
   import pipeline_ctrl_pkg::*;
#(
   parameter int LOAD_STALL_CYC = 1,
   parameter int FLUSH_CYC      = 2,
   parameter int CNT_W          = CNT_W_DEF
) (
   input  logic                   clk,
   input  logic                   rst_n,
   pipeline_hazard_ctrl_if.slave  hz_if,
   output logic [CNT_W-1:0]       stall_count_o,
   output logic [CNT_W-1:0]       flush_count_o,
   output logic [1:0]             ctrl_state_o
);
   localparam logic [4:0] CTL_RUN   = 5'b11001;
   localparam logic [4:0] CTL_STALL = 5'b00011;
   localparam logic [4:0] CTL_FLUSH = 5'b11111;
   localparam logic [4:0] CTL_RST   = 5'b00111;
   ctrl_state_e      state_q, state_d;
   logic [CYC_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] stall_q, stall_d, flush_q, flush_d;
   logic             hazard, stall_inc, flush_inc;
   logic [4:0]       ctl;
   load_use_detect u_detect (
      .id_ex_mem_read_i (hz_if.id_ex_mem_read),
      .id_ex_rd_i       (hz_if.id_ex_rd),
      .if_id_rs1_i      (hz_if.if_id_rs1),
      .if_id_rs2_i      (hz_if.if_id_rs2),
      .hazard_o         (hazard)
   );
   // ctl bit order: pc_write, if_id_write, if_id_flush, id_ex_bubble, id_ex_write
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      stall_inc = 1'b0;
      flush_inc = 1'b0;
      ctl       = CTL_RUN;
      if (hz_if.branch_taken) begin
         ctl       = CTL_FLUSH;
         flush_inc = 1'b1;
         state_d   = (FLUSH_CYC > 1) ? FLUSH : RUN;
         cnt_d     = cyc_load(FLUSH_CYC);
      end else if (hz_if.ext_stall_req) begin
         ctl       = 5'b00000;
         stall_inc = 1'b1;
         state_d   = XSTALL;
         cnt_d     = '0;
      end else begin
         case (state_q)
            FLUSH: begin
               ctl     = CTL_FLUSH;
               state_d = (cnt_q == 3'd1) ? RUN : FLUSH;
               cnt_d   = cnt_q - 1'b1;
            end
            LSTALL: begin
               ctl       = CTL_STALL;
               stall_inc = 1'b1;
               state_d   = (cnt_q == 3'd1) ? RUN : LSTALL;
               cnt_d     = cnt_q - 1'b1;
            end
            default: begin
               state_d = RUN;
               if (hazard) begin
                  ctl       = CTL_STALL;
                  stall_inc = 1'b1;
                  state_d   = (LOAD_STALL_CYC > 1) ? LSTALL : RUN;
                  cnt_d     = cyc_load(LOAD_STALL_CYC);
               end
            end
         endcase
      end
      if (!rst_n) ctl = CTL_RST;
      stall_d = (stall_inc && !(&stall_q)) ? stall_q + 1'b1 : stall_q;
      flush_d = (flush_inc && !(&flush_q)) ? flush_q + 1'b1 : flush_q;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RUN;
         cnt_q   <= '0;
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         stall_q <= stall_d;
         flush_q <= flush_d;
      end
   end
   assign {hz_if.pc_write, hz_if.if_id_write, hz_if.if_id_flush, hz_if.id_ex_bubble, hz_if.id_ex_write} = ctl;
   assign stall_count_o = stall_q;
   assign flush_count_o = flush_q;
   assign ctrl_state_o  = state_q;
endmodule
